// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC dispatcher: function codes, unit indices,
// response status codes, FSM state encoding and operand-count helper.
package cordic_pkg;

  localparam logic [3:0] FN_ATAN  = 4'd0;
  localparam logic [3:0] FN_MAG   = 4'd1;
  localparam logic [3:0] FN_ASIN  = 4'd2;
  localparam logic [3:0] FN_ACOS  = 4'd3;
  localparam logic [3:0] FN_SINH  = 4'd4;
  localparam logic [3:0] FN_COSH  = 4'd5;
  localparam logic [3:0] FN_EXP   = 4'd6;
  localparam logic [3:0] FN_ATANH = 4'd7;
  localparam logic [3:0] FN_LN    = 4'd8;

  localparam int UNIT_W = 3;

  localparam logic [UNIT_W-1:0] U_CIRC    = 3'd0;
  localparam logic [UNIT_W-1:0] U_ASINCOS = 3'd1;
  localparam logic [UNIT_W-1:0] U_HYP     = 3'd2;
  localparam logic [UNIT_W-1:0] U_ATANH   = 3'd3;
  localparam logic [UNIT_W-1:0] U_EXP     = 3'd4;
  localparam logic [UNIT_W-1:0] U_LN      = 3'd5;

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_ILLEGAL = 2'b01,
    ST_TIMEOUT = 2'b10
  } status_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  // Only the circular pair and atanh consume a second operand.
  function automatic logic needs_op2(input logic [3:0] func);
    return (func == FN_ATAN) || (func == FN_MAG) || (func == FN_ATANH);
  endfunction

endpackage

// File: rtl/cordic_dispatch_if.sv
// Request, unit and response signals of the CORDIC dispatcher. Every channel
// uses valid/ready: a transfer happens on a clock edge where both are high, and
// the sender holds its payload stable while valid is high and ready is low.
interface cordic_dispatch_if #(
  parameter int NUM_UNITS = 6,
  parameter int DATA_W    = 16,
  parameter int RES_W     = 32
);
  logic                       req_valid;
  logic                       req_ready;
  logic [3:0]                 req_func;
  logic [DATA_W-1:0]          req_op1;
  logic [DATA_W-1:0]          req_op2;

  logic [NUM_UNITS-1:0]       unit_start;
  logic [3:0]                 unit_func;
  logic [DATA_W-1:0]          unit_op1;
  logic [DATA_W-1:0]          unit_op2;
  logic [NUM_UNITS-1:0]       unit_done;
  logic [NUM_UNITS*RES_W-1:0] unit_result;

  logic                       rsp_valid;
  logic                       rsp_ready;
  logic [RES_W-1:0]           rsp_result;
  logic [1:0]                 rsp_status;

  modport master (
    output req_valid, req_func, req_op1, req_op2,
    input  req_ready,
    input  unit_start, unit_func, unit_op1, unit_op2,
    output unit_done, unit_result,
    input  rsp_valid, rsp_result, rsp_status,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_func, req_op1, req_op2,
    output req_ready,
    output unit_start, unit_func, unit_op1, unit_op2,
    input  unit_done, unit_result,
    output rsp_valid, rsp_result, rsp_status,
    input  rsp_ready
  );
endinterface

// File: rtl/cordic_func_decode.sv
// Maps a function code to the CORDIC unit that executes it, flags illegal codes
// and reports whether the second operand is meaningful.
module cordic_func_decode
  import cordic_pkg::*;
(
  input  logic [3:0]        func_i,
  output logic [UNIT_W-1:0] unit_o,
  output logic              legal_o,
  output logic              needs_op2_o
);

  always_comb begin
    unit_o      = '0;
    legal_o     = 1'b1;
    needs_op2_o = needs_op2(func_i);
    case (func_i)
      FN_ATAN, FN_MAG:   unit_o = U_CIRC;
      FN_ASIN, FN_ACOS:  unit_o = U_ASINCOS;
      FN_SINH, FN_COSH:  unit_o = U_HYP;
      FN_ATANH:          unit_o = U_ATANH;
      FN_EXP:            unit_o = U_EXP;
      FN_LN:             unit_o = U_LN;
      default:           legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cordic_dispatch.sv
// Single-job scheduler: accepts one request, starts exactly one CORDIC unit,
// waits for its done (or a timeout) and holds the result until consumed.
module cordic_dispatch
  import cordic_pkg::*;
#(
  parameter int NUM_UNITS = 6,
  parameter int DATA_W    = 16,
  parameter int RES_W     = 32,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  cordic_dispatch_if.slave bus,
  output logic             busy,
  output state_e           dbg_state_o
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_e               state_q, state_d;
  logic [UNIT_W-1:0]    sel_q, sel_d;
  logic [3:0]           func_q, func_d;
  logic [DATA_W-1:0]    op1_q, op1_d;
  logic [DATA_W-1:0]    op2_q, op2_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [RES_W-1:0]     res_q, res_d;
  status_e              status_q, status_d;
  logic [NUM_UNITS-1:0] start;

  logic [UNIT_W-1:0]    dec_unit;
  logic                 dec_legal;
  logic                 dec_op2;

  cordic_func_decode u_decode (
    .func_i      (bus.req_func),
    .unit_o      (dec_unit),
    .legal_o     (dec_legal),
    .needs_op2_o (dec_op2)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sel_q    <= '0;
      func_q   <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      cnt_q    <= '0;
      res_q    <= '0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      func_q   <= func_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      cnt_q    <= cnt_d;
      res_q    <= res_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    func_d   = func_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    cnt_d    = cnt_q;
    res_d    = res_q;
    status_d = status_q;
    start    = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          func_d = bus.req_func;
          op1_d  = bus.req_op1;
          op2_d  = dec_op2 ? bus.req_op2 : '0;
          sel_d  = dec_unit;
          res_d  = '0;
          if (dec_legal) begin
            status_d = ST_OK;
            state_d  = S_ISSUE;
          end else begin
            status_d = ST_ILLEGAL;
            state_d  = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        start[sel_q] = 1'b1;
        cnt_d        = '0;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the last allowed cycle still counts as success.
        if (bus.unit_done[sel_q]) begin
          res_d    = bus.unit_result[int'(sel_q) * RES_W +: RES_W];
          status_d = ST_OK;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_d    = '0;
          status_d = ST_TIMEOUT;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // req_ready is held low while reset is asserted so every output reads 0.
  assign bus.req_ready  = (state_q == S_IDLE) && !rst;
  assign bus.unit_start = start;
  assign bus.unit_func  = func_q;
  assign bus.unit_op1   = op1_q;
  assign bus.unit_op2   = op2_q;
  assign bus.rsp_valid  = (state_q == S_RESP);
  assign bus.rsp_result = res_q;
  assign bus.rsp_status = status_q;
  assign busy           = (state_q != S_IDLE);
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_cordic_dispatch.sv
// Bench for cordic_dispatch: directed vector table, randomized jobs against a
// function-table reference model, and a reset-during-wait sequence.
module tb_cordic_dispatch;
  import cordic_pkg::*;

  localparam int NU = 6;
  localparam int DW = 16;
  localparam int RW = 32;
  localparam int TO = 64;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   busy;
  state_e dbg_state;

  cordic_dispatch_if #(.NUM_UNITS(NU), .DATA_W(DW), .RES_W(RW)) bus ();

  cordic_dispatch #(.NUM_UNITS(NU), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]    func;
    logic [DW-1:0] op1;
    logic [DW-1:0] op2;
    int            done_unit;
    int            done_k;
    logic [RW-1:0] res;
    int            decoy_unit;
    int            decoy_k;
    int            hold;
    logic [NU-1:0] exp_start;
    logic [DW-1:0] exp_op2;
    logic [1:0]    exp_status;
    logic [RW-1:0] exp_res;
    int            exp_rsp_cycle;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [33:0] exp_q[$];
  int          unit_map[16];
  vec_t        vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                              input int du, input int dk, input logic [RW-1:0] r,
                              input int yu, input int yk, input int h,
                              input logic [NU-1:0] es, input logic [DW-1:0] eo2,
                              input logic [1:0] est, input logic [RW-1:0] eres, input int ecyc);
    vec_t v;
    v.func = f; v.op1 = a; v.op2 = b; v.done_unit = du; v.done_k = dk; v.res = r;
    v.decoy_unit = yu; v.decoy_k = yk; v.hold = h; v.exp_start = es; v.exp_op2 = eo2;
    v.exp_status = est; v.exp_res = eres; v.exp_rsp_cycle = ecyc;
    return v;
  endfunction

  // Reference: which unit serves a function, how many operands it takes and
  // when the response must appear, counted in cycles after the accept edge.
  function automatic vec_t model(input vec_t v);
    vec_t m = v;
    int   u = unit_map[v.func];
    bit   two = (v.func == 4'd0) || (v.func == 4'd1) || (v.func == 4'd7);
    m.exp_op2 = two ? v.op2 : '0;
    if (u < 0) begin
      m.exp_start = '0; m.exp_status = 2'b01; m.exp_res = '0; m.exp_rsp_cycle = 1;
    end else begin
      m.exp_start = NU'(1 << u);
      if (v.done_unit == u && v.done_k >= 1 && v.done_k <= TO) begin
        m.exp_status = 2'b00; m.exp_res = v.res; m.exp_rsp_cycle = v.done_k + 2;
      end else begin
        m.exp_status = 2'b10; m.exp_res = '0; m.exp_rsp_cycle = TO + 2;
      end
    end
    return m;
  endfunction

  // driver tasks
  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b0; bus.unit_done = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".hs"}, 64'({bus.req_ready, bus.rsp_valid, busy, bus.unit_start}), 64'(0));
    check({tag, ".unit_regs"}, 64'({bus.unit_func, bus.unit_op1, bus.unit_op2}), 64'(0));
    check({tag, ".rsp_regs"}, 64'({bus.rsp_result, bus.rsp_status}), 64'(0));
    check({tag, ".state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  task automatic run_job(input vec_t v, input string tag);
    int            cyc, rsp_cyc, start_cnt, start_cyc, bad, hold_bad;
    logic [NU-1:0] start_val;
    logic [RW-1:0] got_res;
    logic [1:0]    got_st;
    logic [33:0]   e;
    for (int i = 0; i < NU; i++) bus.unit_result[i*RW +: RW] = $urandom();
    if (v.done_unit >= 0) bus.unit_result[v.done_unit*RW +: RW] = v.res;
    exp_q.push_back({v.exp_status, v.exp_res});
    check({tag, ".idle_ready"}, 64'(bus.req_ready), 64'(1));
    bus.req_valid = 1'b1; bus.req_func = v.func; bus.req_op1 = v.op1; bus.req_op2 = v.op2;
    cyc = 0; rsp_cyc = -1; start_cnt = 0; start_cyc = -1; start_val = '0; bad = 0;
    got_res = '0; got_st = '0;
    while (rsp_cyc < 0 && cyc < 4 * TO) begin
      @(negedge clk);
      cyc++;
      bus.req_valid = 1'($urandom_range(0, 1));
      bus.req_func  = 4'($urandom());
      bus.req_op1   = DW'($urandom());
      bus.req_op2   = DW'($urandom());
      bus.unit_done = '0;
      if (bus.unit_start != '0) begin
        start_cnt++; start_val = bus.unit_start; start_cyc = cyc;
      end
      if (bus.rsp_valid) begin
        rsp_cyc = cyc; got_res = bus.rsp_result; got_st = bus.rsp_status;
      end else begin
        if (bus.req_ready || !busy) bad++;
        if (v.done_unit >= 0 && cyc == v.done_k + 1) bus.unit_done[v.done_unit] = 1'b1;
        if (v.decoy_unit >= 0 && cyc == v.decoy_k + 1) bus.unit_done[v.decoy_unit] = 1'b1;
      end
    end
    check({tag, ".rsp_seen"}, 64'(rsp_cyc >= 0), 64'(1));
    check({tag, ".start_count"}, 64'(start_cnt), 64'((v.exp_start != '0) ? 1 : 0));
    check({tag, ".start_vec"}, 64'(start_val), 64'(v.exp_start));
    if (v.exp_start != '0) check({tag, ".start_cycle"}, 64'(start_cyc), 64'(1));
    check({tag, ".busy_not_ready"}, 64'(bad), 64'(0));
    if (rsp_cyc >= 0) begin
      e = exp_q.pop_front();
      check({tag, ".rsp_cycle"}, 64'(rsp_cyc), 64'(v.exp_rsp_cycle));
      check({tag, ".status"}, 64'(got_st), 64'(e[33:32]));
      check({tag, ".result"}, 64'(got_res), 64'(e[31:0]));
      check({tag, ".unit_func"}, 64'(bus.unit_func), 64'(v.func));
      check({tag, ".unit_op1"}, 64'(bus.unit_op1), 64'(v.op1));
      check({tag, ".unit_op2"}, 64'(bus.unit_op2), 64'(v.exp_op2));
      hold_bad = 0;
      for (int h = 0; h < v.hold; h++) begin
        @(negedge clk);
        bus.req_valid = 1'($urandom_range(0, 1));
        if (!bus.rsp_valid || bus.rsp_result !== got_res || bus.rsp_status !== got_st ||
            bus.req_ready || bus.unit_func !== v.func || bus.unit_op1 !== v.op1 ||
            bus.unit_op2 !== v.exp_op2) hold_bad++;
      end
      if (v.hold > 0) check({tag, ".hold_stable"}, 64'(hold_bad), 64'(0));
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check({tag, ".release"}, 64'({bus.rsp_valid, bus.req_ready, busy}), 64'(3'b010));
    end else begin
      void'(exp_q.pop_back());
      do_reset();
    end
  endtask

  initial begin
    int bad;
    unit_map = '{0, 0, 1, 1, 2, 2, 4, 3, 5, -1, -1, -1, -1, -1, -1, -1};

    vecs[0]  = mk(4'd0,  16'h2000, 16'h1000, 0, 5,    32'h0000_1DAC, -1, 0, 0,
                  6'b000001, 16'h1000, 2'b00, 32'h0000_1DAC, 7);
    vecs[1]  = mk(4'd4,  16'h0100, 16'hFFFF, 2, 3,    32'h1234_5678, -1, 0, 1,
                  6'b000100, 16'h0000, 2'b00, 32'h1234_5678, 5);
    vecs[2]  = mk(4'd12, 16'hAAAA, 16'h5555, -1, 0,   32'h0,          0, 1, 0,
                  6'b000000, 16'h0000, 2'b01, 32'h0, 1);
    vecs[3]  = mk(4'd8,  16'h4000, 16'h0123, 5, 1000, 32'h5555_AAAA, -1, 0, 0,
                  6'b100000, 16'h0000, 2'b10, 32'h0, 66);
    vecs[4]  = mk(4'd8,  16'h4001, 16'h0123, 5, 63,   32'h0000_ABCD, -1, 0, 0,
                  6'b100000, 16'h0000, 2'b00, 32'h0000_ABCD, 65);
    vecs[5]  = mk(4'd8,  16'h4002, 16'h0123, 5, 64,   32'h0000_0042, -1, 0, 0,
                  6'b100000, 16'h0000, 2'b00, 32'h0000_0042, 66);
    vecs[6]  = mk(4'd2,  16'h0800, 16'h0F0F, 1, 8,    32'h0000_3C00,  3, 5, 10,
                  6'b000010, 16'h0000, 2'b00, 32'h0000_3C00, 10);
    vecs[7]  = mk(4'd7,  16'h0200, 16'h7777, 3, 1,    32'h1111_2222,  0, 1, 0,
                  6'b001000, 16'h7777, 2'b00, 32'h1111_2222, 3);
    vecs[8]  = mk(4'd6,  16'hF000, 16'h3333, 4, 2,    32'h8000_0001, -1, 0, 2,
                  6'b010000, 16'h0000, 2'b00, 32'h8000_0001, 4);
    vecs[9]  = mk(4'd1,  16'h7FFF, 16'h8000, 0, 1,    32'h0000_FFFF,  5, 1, 0,
                  6'b000001, 16'h8000, 2'b00, 32'h0000_FFFF, 3);
    vecs[10] = mk(4'd9,  16'h1111, 16'h2222, -1, 0,   32'h0,          1, 1, 3,
                  6'b000000, 16'h0000, 2'b01, 32'h0, 1);

    bus.req_valid = 1'b0; bus.req_func = '0; bus.req_op1 = '0; bus.req_op2 = '0;
    bus.unit_done = '0; bus.unit_result = '0; bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_job(vecs[i], $sformatf("vec%0d", i));

    // reset while waiting on unit 0, followed by a late done from that unit
    bus.unit_result = '0;
    bus.unit_result[RW-1:0] = 32'hCAFE_0001;
    bus.req_valid = 1'b1; bus.req_func = 4'd0; bus.req_op1 = 16'h1234; bus.req_op2 = 16'h5678;
    repeat (3) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    bus.unit_done[0] = 1'b1;
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      bus.unit_done = '0;
      if (bus.rsp_valid || busy || bus.unit_start != '0 || !bus.req_ready ||
          bus.rsp_result != '0 || bus.unit_func != '0) bad++;
    end
    check("mid_rst.late_done_ignored", 64'(bad), 64'(0));
    run_job(vecs[0], "post_rst");

    for (int j = 0; j < 40; j++) begin
      vec_t v;
      int   r;
      v = vecs[0];
      v.func = 4'($urandom_range(0, 15));
      v.op1  = DW'($urandom());
      v.op2  = DW'($urandom());
      v.res  = $urandom();
      v.done_unit = unit_map[v.func];
      r = $urandom_range(0, 9);
      v.done_k = (r < 7) ? $urandom_range(1, 10) : $urandom_range(60, 70);
      v.decoy_unit = (v.done_unit + $urandom_range(1, 5)) % NU;
      v.decoy_k = $urandom_range(1, 12);
      v.hold = $urandom_range(0, 3);
      v = model(v);
      run_job(v, $sformatf("rnd%0d", j));
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_dispatch.md
Name: cordic_dispatch

Overview:
- Single-job scheduler for the CORDIC function units (atan/magnitude, asin/acos, sinh/cosh, atanh, e^x, ln).
- Accepts one request (func code plus two operands) from the front-panel control FSM and decodes func to a unit.
- Issues a one-cycle start to exactly one unit, waits for that unit's done, and captures its result into one shared result register.
- Removes the multiple-driver result bus. Exactly one unit is active at any time.

Parameters:
- NUM_UNITS, 6, number of function units; unit_start/unit_done width.
- DATA_W, 16, operand width (signed two's complement).
- RES_W, 32, unit result and response width.
- TIMEOUT, 64, WAIT cycles allowed before a timeout response; must be ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  dispatcher can accept a request
- req_func  in  4  function code
- req_op1  in  DATA_W  operand 1
- req_op2  in  DATA_W  operand 2
- unit_start  out  NUM_UNITS  one-hot, one-cycle start pulse
- unit_func  out  4  registered func code to units
- unit_op1  out  DATA_W  registered operand 1
- unit_op2  out  DATA_W  registered operand 2; forced to 0 for single-operand funcs
- unit_done  in  NUM_UNITS  per-unit completion pulse
- unit_result  in  NUM_UNITS*RES_W  flattened results; unit i at [i*RES_W +: RES_W]
- rsp_valid  out  1  response held
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  RES_W  captured result
- rsp_status  out  2  00 ok, 01 illegal func, 10 timeout
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state IDLE; timeout counter 0.
- Func decode:
  - 0 atan→u0, 1 mag→u0
  - 2 asin→u1, 3 acos→u1
  - 4 sinh→u2, 5 cosh→u2
  - 7 atanh→u3
  - 6 e^x→u4
  - 8 ln→u5
  - 9..15 illegal
- Two-operand funcs: 0, 1, 7.

State machine:
- IDLE:
  - req_ready=1.
  - On req_valid: latch func/op1/op2 into the unit_* registers and the decoded unit index.
  - Legal func → ISSUE. Illegal func → RESP with status 01 and result 0.
  - req_ready is 0 in every other state.
- ISSUE (1 cycle):
  - unit_start[sel]=1; counter cleared → WAIT.
- WAIT:
  - unit_done[sel]=1 → rsp_result ← unit_result slice sel, status 00 → RESP.
  - Otherwise counter+1. Counter reaching TIMEOUT-1 with no done → result 0, status 10 → RESP.
  - Done and timeout in the same cycle: done wins.
  - done from unselected units is ignored in all states.
- RESP:
  - rsp_valid=1; rsp_result/rsp_status held stable.
  - On rsp_ready → IDLE, with rsp_valid dropping next cycle.
  - A new request is accepted no earlier than the IDLE cycle.

Latency and stability:
- Accept at cycle t → start at t+1.
- Done sampled at cycle d → rsp_valid at d+1.
- Illegal func → rsp_valid at t+1.
- unit_func/unit_op1/unit_op2 hold stable from ISSUE until the next accept.

Reset mid-operation:
- Any state returns to IDLE with all outputs 0.
- A late unit_done after reset is ignored because state is IDLE.

Decomposition:
- cordic_pkg holds:
  - func code constants
  - unit index constants
  - status codes (ST_OK, ST_ILLEGAL, ST_TIMEOUT)
  - the needs_op2 function
  - state encoding
- Sub-module cordic_func_decode (combinational): func → unit index, legal flag, needs_op2.
- The FSM, counter and capture registers live in cordic_dispatch.

Test Plan:
- func=0, op1=16'h2000, op2=16'h1000; u0 done 5 cycles after start with result 32'h0000_1DAC → one start pulse on bit0; rsp_valid 1 cycle after done; result 32'h0000_1DAC; status 00; unit_op2=16'h1000.
- func=4, op2=16'hFFFF → unit_start=6'b000100; unit_op2=0; u2 result 32'h1234_5678 → rsp ok with that value.
- func=12 → no start pulse; rsp_valid 1 cycle after accept; status 01; result 0.
- func=8, u5 never done → rsp at WAIT cycle 64 with status 10 and result 0. Repeat with done on cycle 63 → status 00.
- func=2, u3 done and u1 done 3 cycles apart, u3 first → u3 ignored; result taken from u1. Hold rsp_ready=0 for 10 cycles → rsp fields stable; req_ready=0 throughout.
- rst asserted in WAIT, then u0 done pulses → all outputs 0; state IDLE; no rsp_valid. Next request completes normally.
